// File: rtl/banked_sram_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module : banked_sram_mp_pkg
// Desc   : Shared types, constants and helpers for the banked multi-port SRAM.
// Rev    : 1.0 - initial release
// ============================================================================
package banked_sram_mp_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // BW describes the default geometry; instances derive their own width from NB.
  localparam int c_NB_DEFAULT = 8;
  localparam int BW           = clog2(c_NB_DEFAULT);

  // Tag id is sized for up to 256 masters; instances use the low clog2(M) bits.
  localparam int c_TAG_ID_W   = 8;

  localparam int c_MAP_INTERLEAVED = 0;
  localparam int c_MAP_BLOCKED     = 1;

  typedef struct packed {
    logic                  valid;
    logic [c_TAG_ID_W-1:0] id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/banked_sram_mp_bank.sv
`default_nettype none
// ============================================================================
// Module : banked_sram_mp_bank
// Desc   : One bank: round-robin arbiter, request mux, strobed array, read pipe.
// Rev    : 1.0 - initial release
// ============================================================================
module banked_sram_mp_bank
  import banked_sram_mp_pkg::*;
#(
  parameter int M      = 8,
  parameter int IN_AW  = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [M-1:0]              i_hit,
  input  logic [M-1:0]              i_we,
  input  logic [M*IN_AW-1:0]        i_addr,
  input  logic [M*DATA_W-1:0]       i_wdata,
  input  logic [M*(DATA_W/8)-1:0]   i_wstrb,
  output logic [M-1:0]              o_gnt,
  output tag_t                      o_tag,
  output logic [DATA_W-1:0]         o_rdata
);

  localparam int c_IDW   = clog2(M);
  localparam int c_NBYTE = DATA_W / 8;
  localparam int c_DEPTH = 1 << IN_AW;

  logic [c_IDW-1:0]   r_ptr;
  logic [c_IDW-1:0]   w_gnt_id;
  logic               w_any;
  logic               w_we;
  logic [IN_AW-1:0]   w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic [c_NBYTE-1:0] w_wstrb;
  tag_t               w_tag_in;

  logic [DATA_W-1:0]  r_mem [c_DEPTH];
  logic [DATA_W-1:0]  r_rd;
  tag_t               r_tag [RD_LAT];

  always_comb begin
    w_any    = 1'b0;
    w_gnt_id = '0;
    for (int i = 0; i < M; i++) begin
      int j;
      j = int'(r_ptr) + i;
      if (j >= M) j = j - M;
      if (!w_any && i_hit[j]) begin
        w_any    = 1'b1;
        w_gnt_id = c_IDW'(j);
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    if (w_any) o_gnt[w_gnt_id] = 1'b1;
  end

  assign w_we    = i_we[w_gnt_id];
  assign w_addr  = i_addr[int'(w_gnt_id)*IN_AW +: IN_AW];
  assign w_wdata = i_wdata[int'(w_gnt_id)*DATA_W +: DATA_W];
  assign w_wstrb = i_wstrb[int'(w_gnt_id)*c_NBYTE +: c_NBYTE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (int'(w_gnt_id) == M - 1) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // Single port: a cycle carries either one write or one read.
  always_ff @(posedge clk) begin
    if (w_any && w_we) begin
      for (int b = 0; b < c_NBYTE; b++) begin
        if (w_wstrb[b]) r_mem[w_addr][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
    if (w_any && !w_we) r_rd <= r_mem[w_addr];
  end

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_any & ~w_we;
    w_tag_in.id    = c_TAG_ID_W'(w_gnt_id);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int k = 1; k < RD_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign o_tag = r_tag[RD_LAT-1];

  // Data stages need no reset: the top gates them with the tag valid.
  if (RD_LAT > 1) begin : g_dpipe
    logic [DATA_W-1:0] r_dpipe [RD_LAT-1];
    always_ff @(posedge clk) begin
      r_dpipe[0] <= r_rd;
      for (int k = 1; k < RD_LAT - 1; k++) r_dpipe[k] <= r_dpipe[k-1];
    end
    assign o_rdata = r_dpipe[RD_LAT-2];
  end else begin : g_dpipe_none
    assign o_rdata = r_rd;
  end

endmodule
`default_nettype wire

// File: rtl/banked_sram_mp.sv
`default_nettype none
// ============================================================================
// Module : banked_sram_mp
// Desc   : M-master, NB-bank scratchpad; optional counters via BANKED_SRAM_MP_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module banked_sram_mp
  import banked_sram_mp_pkg::*;
#(
  parameter int NB       = 8,
  parameter int M        = 8,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 2,
  parameter int MAP_MODE = c_MAP_INTERLEAVED
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [M-1:0]              req_v,
  input  logic [M-1:0]              req_we,
  input  logic [M*ADDR_W-1:0]       req_addr,
  input  logic [M*DATA_W-1:0]       req_wdata,
  input  logic [M*(DATA_W/8)-1:0]   req_wstrb,
  output logic [M-1:0]              req_ready,
  output logic [M-1:0]              rsp_v,
  output logic [M*DATA_W-1:0]       rsp_rdata
`ifdef BANKED_SRAM_MP_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [M*16-1:0]           stat_conflict,
  output logic [NB*16-1:0]          stat_busy
`endif
);

  localparam int c_BW    = (NB == c_NB_DEFAULT) ? BW : clog2(NB);
  localparam int c_IN_AW = ADDR_W - c_BW;

  logic [c_BW-1:0]      w_bank [M];
  logic [M*c_IN_AW-1:0] w_in_addr;
  logic [M-1:0]         w_hit  [NB];
  logic [M-1:0]         w_gnt  [NB];
  tag_t                 w_tag  [NB];
  logic [DATA_W-1:0]    w_rdata[NB];

  for (genvar m = 0; m < M; m++) begin : g_decode
    if (MAP_MODE == c_MAP_BLOCKED) begin : g_blocked
      assign w_bank[m] = req_addr[m*ADDR_W + ADDR_W - 1 -: c_BW];
      assign w_in_addr[m*c_IN_AW +: c_IN_AW] = req_addr[m*ADDR_W +: c_IN_AW];
    end else begin : g_interleaved
      assign w_bank[m] = req_addr[m*ADDR_W +: c_BW];
      assign w_in_addr[m*c_IN_AW +: c_IN_AW] = req_addr[m*ADDR_W + c_BW +: c_IN_AW];
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    for (genvar m = 0; m < M; m++) begin : g_hit
      assign w_hit[b][m] = req_v[m] && (w_bank[m] == c_BW'(b));
    end

    banked_sram_mp_bank #(
      .M      (M),
      .IN_AW  (c_IN_AW),
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_hit   (w_hit[b]),
      .i_we    (req_we),
      .i_addr  (w_in_addr),
      .i_wdata (req_wdata),
      .i_wstrb (req_wstrb),
      .o_gnt   (w_gnt[b]),
      .o_tag   (w_tag[b]),
      .o_rdata (w_rdata[b])
    );
  end

  always_comb begin
    req_ready = '0;
    for (int b = 0; b < NB; b++) req_ready = req_ready | w_gnt[b];
  end

  // A master holds at most one grant per cycle, so at most one bank matches its id.
  always_comb begin
    rsp_v     = '0;
    rsp_rdata = '0;
    for (int b = 0; b < NB; b++) begin
      for (int m = 0; m < M; m++) begin
        if (w_tag[b].valid && (w_tag[b].id == c_TAG_ID_W'(m))) begin
          rsp_v[m] = 1'b1;
          rsp_rdata[m*DATA_W +: DATA_W] = rsp_rdata[m*DATA_W +: DATA_W] | w_rdata[b];
        end
      end
    end
  end

`ifdef BANKED_SRAM_MP_STATS_EN
  for (genvar m = 0; m < M; m++) begin : g_stat_conflict
    logic [15:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (stat_clr) begin
        r_cnt <= '0;
      end else if (req_v[m] && !req_ready[m] && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign stat_conflict[m*16 +: 16] = r_cnt;
  end

  for (genvar b = 0; b < NB; b++) begin : g_stat_busy
    logic [15:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (stat_clr) begin
        r_cnt <= '0;
      end else if ((|w_gnt[b]) && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign stat_busy[b*16 +: 16] = r_cnt;
  end
`endif

endmodule
`default_nettype wire
